pipe_scoreboard: RTL

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: register-hazard scoreboard for an in-order pipeline.
// Tracks the destination register of every in-flight instruction from EX
// (stage 0) to WB (stage STAGES-1), stalls ID on unresolved hazards and,
// when forwarding is built in, reports which stage can supply each source.
// Build option: define PIPE_SCB_FWD_EN to enable operand forwarding; without
// it every in-flight match stalls ID and the forwarding outputs stay at 0.
module pipe_scoreboard #(
  parameter int STAGES = 3,
  parameter int REG_W  = 5
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_rs,
  input  logic [REG_W-1:0]             id_rt,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic [REG_W-1:0]             id_rd,
  input  logic                         id_wr,
  input  logic                         id_load,
  input  logic                         flush,
  output logic                         stall,
  output logic                         issue,
  output logic [$clog2(STAGES+1)-1:0]  fwd_a,
  output logic [$clog2(STAGES+1)-1:0]  fwd_b,
  output logic                         wb_valid,
  output logic [REG_W-1:0]             wb_rd,
  output logic [15:0]                  stall_cnt
);

  localparam int FW = $clog2(STAGES+1);

  // Per-stage entry: valid bit, destination index, load flag.
  logic [STAGES-1:0] stV;
  logic [STAGES-1:0] stLd;
  logic [REG_W-1:0]  stRd [STAGES];
  logic [STAGES-1:0] matchA;
  logic [STAGES-1:0] matchB;
  logic              anyMatch;
  logic              loadUse;
  logic [15:0]       stallCnt;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : gMatch
    // Register 0 is hardwired, so it never creates a dependency.
    assign matchA[gi] = id_rs_used && (id_rs != '0) && stV[gi] && (stRd[gi] == id_rs);
    assign matchB[gi] = id_rt_used && (id_rt != '0) && stV[gi] && (stRd[gi] == id_rt);
  end

  assign anyMatch = (|matchA) | (|matchB);
  // A load in EX has no result yet, so it cannot be forwarded this cycle.
  assign loadUse  = (matchA[0] | matchB[0]) & stLd[0];

`ifdef PIPE_SCB_FWD_EN
  logic [FW-1:0] selA;
  logic [FW-1:0] selB;

  // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (matchA[i]) selA = FW'(i+1);
      if (matchB[i]) selB = FW'(i+1);
    end
  end

  assign stall = id_valid & ~flush & loadUse;
  assign fwd_a = selA;
  assign fwd_b = selB;
`else
  // loadUse is a subset of anyMatch; both are listed to make the rule explicit.
  assign stall = id_valid & ~flush & (anyMatch | loadUse);
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  assign issue     = id_valid & ~stall & ~flush;
  assign wb_valid  = stV[STAGES-1];
  assign wb_rd     = stRd[STAGES-1];
  assign stall_cnt = stallCnt;

  // Valid bits shift one stage per edge; flush kills the entry leaving EX.
  always_ff @(posedge clk) begin
    if (clr) begin
      stV <= '0;
    end else begin
      stV[0] <= issue & id_wr & (id_rd != '0);
      for (int i = 1; i < STAGES; i++) begin
        stV[i] <= (i == 1) ? (stV[0] & ~flush) : stV[i-1];
      end
    end
  end

  // Payload shifts unconditionally; it is only meaningful where stV is set.
  always_ff @(posedge clk) begin
    stRd[0] <= id_rd;
    stLd[0] <= id_load;
    for (int i = 1; i < STAGES; i++) begin
      stRd[i] <= stRd[i-1];
      stLd[i] <= stLd[i-1];
    end
  end

  // Stalled-cycle counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

endmodule
